// File: rtl/legv8_alu.sv
// 64-bit LEGv8 execute-stage ALU with registered result and {V,C,N,Z} flags.
// Optional build macro LEGV8_ALU_ASR_EN turns FS[4:2]=110 into an arithmetic shift right.
module legv8_alu (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [4:0]  FS,
  input  logic        C0,
  output logic [63:0] F,
  output logic [3:0]  status
);

  localparam int unsigned W = 64;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LSL = 3'b100;
  localparam logic [2:0] OP_LSR = 3'b101;
  localparam logic [2:0] OP_ASR = 3'b110;

  logic [W-1:0] a2;
  logic [W-1:0] b2;
  logic [W:0]   sum;
  logic [5:0]   shamt;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;

  assign a2    = FS[1] ? ~A : A;
  assign b2    = FS[0] ? ~B : B;
  assign sum   = {1'b0, a2} + {1'b0, b2} + {64'd0, C0};
  assign shamt = B[5:0];

  // Result mux; every select code maps to a defined value.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (FS[4:2])
      OP_AND: result = a2 & b2;
      OP_OR:  result = a2 | b2;
      OP_ADD: begin
        result = sum[W-1:0];
        carry  = sum[W];
        ovf    = (a2[W-1] == b2[W-1]) && (sum[W-1] != a2[W-1]);
      end
      OP_XOR: result = a2 ^ b2;
      OP_LSL: result = A << shamt;
      OP_LSR: result = A >> shamt;
`ifdef LEGV8_ALU_ASR_EN
      OP_ASR: result = $unsigned($signed(A) >>> shamt);
`else
      OP_ASR: result = '0;
`endif
      default: result = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      F      <= '0;
      status <= 4'b0000;
    end else begin
      F      <= result;
      status <= {ovf, carry, result[W-1], (result == '0)};
    end
  end

endmodule

// File: tb/tb_legv8_alu.sv
// Self-checking bench for legv8_alu: directed corner cases plus random ops against a reference model.
module tb_legv8_alu;

  logic        clock;
  logic        reset_n;
  logic [63:0] A;
  logic [63:0] B;
  logic [4:0]  FS;
  logic        C0;
  logic [63:0] F;
  logic [3:0]  status;

  int n_cmp;
  int n_bad;

  legv8_alu dut (
    .clock  (clock),
    .reset_n(reset_n),
    .A      (A),
    .B      (B),
    .FS     (FS),
    .C0     (C0),
    .F      (F),
    .status (status)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got status=%b F=%h, expected status=%b F=%h",
               tag, got[67:64], got[63:0], exp[67:64], exp[63:0]);
    end
  endtask

  // Reference: arithmetic meaning of each op; returns {V,C,N,Z,F}.
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [4:0] fs, input logic c0);
    logic [63:0] a2, b2, r;
    logic        v, c;
    logic signed [65:0] s;
    int unsigned sh;
    a2 = fs[1] ? ~a : a;
    b2 = fs[0] ? ~b : b;
    sh = int'(b[5:0]);
    r = 64'd0;
    v = 1'b0;
    c = 1'b0;
    case (int'(fs[4:2]))
      0: r = a2 & b2;
      1: r = a2 | b2;
      2: begin
        r = a2 + b2 + 64'(c0);
        // unsigned carry: a2+b2+c0 >= 2^64
        c = (a2 > ~b2) || (c0 && (a2 == ~b2));
        // signed overflow: true sum out of 64-bit two's complement range
        s = $signed({{2{a2[63]}}, a2}) + $signed({{2{b2[63]}}, b2}) + $signed({65'd0, c0});
        v = (s > $signed(66'h0_7FFF_FFFF_FFFF_FFFF)) || (s < -$signed(66'h0_8000_0000_0000_0000));
      end
      3: r = a2 ^ b2;
      4: r = a << sh;
      5: r = a >> sh;
`ifdef LEGV8_ALU_ASR_EN
      6: r = $unsigned($signed(a) >>> sh);
`endif
      default: r = 64'd0;
    endcase
    return {v, c, r[63], (r == 64'd0), r};
  endfunction

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] fs, input logic c0);
    @(negedge clock);
    A = a; B = b; FS = fs; C0 = c0;
    @(posedge clock);
    #1;
    check(tag, {status, F}, model(a, b, fs, c0));
  endtask

  task automatic run_exp(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] fs, input logic c0,
                         input logic [63:0] ef, input logic [3:0] es);
    @(negedge clock);
    A = a; B = b; FS = fs; C0 = c0;
    @(posedge clock);
    #1;
    check(tag, {status, F}, {es, ef});
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [63:0] corners [6];
    n_cmp = 0;
    n_bad = 0;
    corners[0] = 64'd0;
    corners[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h8000_0000_0000_0000;
    corners[4] = 64'd1;
    corners[5] = 64'h5555_AAAA_0F0F_F0F0;

    reset_n = 1'b0;
    A = 64'd3; B = 64'd2; FS = 5'b01000; C0 = 1'b0;
    @(posedge clock);
    #1;
    check("reset", {status, F}, 68'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_exp("and",      64'd3, 64'd2, 5'b00000, 1'b0, 64'd2, 4'b0000);
    run_exp("or",       64'd3, 64'd2, 5'b00100, 1'b0, 64'd3, 4'b0000);
    run_exp("xor",      64'd3, 64'd2, 5'b01100, 1'b0, 64'd1, 4'b0000);
    run_exp("nor",      64'd3, 64'd2, 5'b00011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0010);
    run_exp("nand",     64'd3, 64'd2, 5'b00111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0010);
    run_exp("add",      64'd3, 64'd2, 5'b01000, 1'b0, 64'd5, 4'b0000);
    run_exp("sub",      64'd3, 64'd2, 5'b01001, 1'b1, 64'd1, 4'b0100);
    run_exp("sub_neg",  64'd2, 64'd3, 5'b01001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
    run_exp("ovf",      64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0,
             64'h8000_0000_0000_0000, 4'b1010);
    run_exp("wrap",     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'd0, 4'b0101);
    run_exp("lsl63",    64'd1, 64'd63, 5'b10000, 1'b0, 64'h8000_0000_0000_0000, 4'b0010);
    run_exp("lsr63",    64'h8000_0000_0000_0000, 64'd63, 5'b10100, 1'b0, 64'd1, 4'b0000);
    run_exp("lsl0",     64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFC0, 5'b10011, 1'b0,
             64'h1234_5678_9ABC_DEF0, 4'b0000);
    run_exp("lsr0",     64'h8234_5678_9ABC_DEF0, 64'd0, 5'b10110, 1'b1,
             64'h8234_5678_9ABC_DEF0, 4'b0010);
    run_exp("unused7",  64'hDEAD, 64'h1, 5'b11100, 1'b1, 64'd0, 4'b0001);
`ifdef LEGV8_ALU_ASR_EN
    run_exp("asr",      64'h8000_0000_0000_0000, 64'd4, 5'b11000, 1'b0,
             64'hF800_0000_0000_0000, 4'b0010);
`else
    run_exp("unused6",  64'h8000_0000_0000_0000, 64'd4, 5'b11000, 1'b0, 64'd0, 4'b0001);
`endif

    // Mid-stream reset discards the op sampled on that edge.
    @(negedge clock);
    A = 64'd7; B = 64'd9; FS = 5'b01000; C0 = 1'b1; reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("reset_mid", {status, F}, 68'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int fs = 0; fs < 32; fs++) begin
      for (int k = 0; k < 6; k++) begin
        run_op("corner", corners[k], corners[(k + fs) % 6], 5'(fs), 1'(k[0]));
      end
    end

    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      run_op("random", ra, rb, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
